// File: rtl/intc_bamse.sv
`default_nettype none
// ============================================================================
// Module   : intc_bamse
// Purpose  : Eight-source rising-edge interrupt controller for the BAMSE
//            PicoBlaze bus. Maskable pending register, fixed priority
//            (bit 0 highest), request/acknowledge handshake, vector register.
// Revision : 1.0 - initial release
// ============================================================================
module intc_bamse #(
  parameter logic [7:0] ADDR_MASK = 8'h01,
  parameter logic [7:0] ADDR_PEND = 8'h02,
  parameter logic [7:0] ADDR_VEC  = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_src,
  input  logic [7:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       ren,
  input  logic       wen,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] src_d;
  logic [7:0] mask;
  logic [7:0] pending;
  logic [2:0] vector;

  logic [7:0] rise;
  logic [7:0] pend_clr;
  logic [7:0] active;
  logic [2:0] winner;
  logic       busy;

  assign rise     = irq_src & ~src_d;
  assign pend_clr = (wen && (address == ADDR_PEND)) ? data_in : 8'h00;
  assign active   = pending & mask;
  assign busy     = (state != S_IDLE);

  // Lowest set index of the active sources wins arbitration.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) winner = i[2:0];
    end
  end

  // Source history, pending capture (set beats write-1-to-clear) and mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_d   <= 8'h00;
      pending <= 8'h00;
      mask    <= 8'h00;
    end else begin
      src_d   <= irq_src;
      pending <= (pending & ~pend_clr) | rise;
      if (wen && (address == ADDR_MASK)) mask <= data_in;
    end
  end

  // Request/acknowledge sequencer; the vector is frozen while a request is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      interrupt <= 1'b0;
      vector    <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|active) begin
            vector    <= winner;
            interrupt <= 1'b1;
            state     <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          // Ack takes precedence over a source being withdrawn in the same cycle.
          if (interrupt_ack) begin
            interrupt <= 1'b0;
            state     <= S_SERVICE;
          end else if (!active[vector]) begin
            interrupt <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_SERVICE: begin
          // Only clearing the pending bit ends service; masking it does not.
          if (!pending[vector]) state <= S_IDLE;
        end
        default: begin
          interrupt <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Side-effect-free read mux; zero when not reading or address unmatched.
  always_comb begin
    data_out = 8'h00;
    if (ren) begin
      if (address == ADDR_MASK)      data_out = mask;
      else if (address == ADDR_PEND) data_out = pending;
      else if (address == ADDR_VEC)  data_out = {busy, 4'b0000, vector};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_intc_bamse.sv
`default_nettype none
// ============================================================================
// Module   : tb_intc_bamse
// Purpose  : Self-checking bench for intc_bamse: directed scenarios plus
//            randomized traffic against a behavioural controller model, with
//            expectations queued by the driver and checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intc_bamse;

  localparam logic [7:0] A_MASK = 8'h01;
  localparam logic [7:0] A_PEND = 8'h02;
  localparam logic [7:0] A_VEC  = 8'h03;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq_src = 8'h00;
  logic [7:0] address = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       ren = 1'b0;
  logic       wen = 1'b0;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       intr;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  // Behavioural model: what software would observe.
  logic [7:0] m_mask, m_pend, m_prev;
  int         m_phase;   // 0 = waiting, 1 = request raised, 2 = being serviced
  int         m_vec;
  logic       m_intr;

  intc_bamse #(
    .ADDR_MASK(A_MASK), .ADDR_PEND(A_PEND), .ADDR_VEC(A_VEC)
  ) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .address(address),
    .data_in(data_in), .data_out(data_out), .ren(ren), .wen(wen),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mask = 0; m_pend = 0; m_prev = 0; m_phase = 0; m_vec = 0; m_intr = 0;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == A_MASK)      v = m_mask;
    else if (a == A_PEND) v = m_pend;
    else if (a == A_VEC)  v = {(m_phase != 0), 4'b0000, 3'(m_vec)};
    return v;
  endfunction

  function automatic void model_step(input logic [7:0] irq, input logic [7:0] a,
                                     input logic [7:0] d, input logic w, input logic k);
    logic [7:0] act, newp;
    act = m_pend & m_mask;
    if (m_phase == 0) begin
      if (act != 0) begin
        for (int i = 0; i < 8; i++) begin
          if (act[i]) begin m_vec = i; break; end
        end
        m_intr = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (k) begin m_intr = 0; m_phase = 2; end
      else if (!act[m_vec]) begin m_intr = 0; m_phase = 0; end
    end else begin
      if (!m_pend[m_vec]) m_phase = 0;
    end
    newp = m_pend;
    if (w && a == A_PEND) newp = newp & ~d;
    newp = newp | (irq & ~m_prev);
    m_pend = newp;
    m_prev = irq;
    if (w && a == A_MASK) m_mask = d;
  endfunction

  // One bus cycle: drive, queue the expected response, advance the model.
  // exp_rd >= 0 additionally compares data_out with that fixed value.
  task automatic cycle(input logic [7:0] irq, input logic [7:0] a, input logic [7:0] d,
                       input logic r, input logic w, input logic k,
                       input int exp_rd = -1, input string name = "");
    exp_t e;
    @(negedge clk);
    irq_src = irq; address = a; data_in = d; ren = r; wen = w; interrupt_ack = k;
    #1;
    e.intr = m_intr;
    e.data = r ? model_read(a) : 8'h00;
    sb.push_back(e);
    if (exp_rd >= 0) chk(name, data_out, 8'(exp_rd));
    @(posedge clk);
    model_step(irq, a, d, w, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cycle(8'h00, a, d, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input int exp, input string name);
    cycle(8'h00, a, 8'h00, 1'b1, 1'b0, 1'b0, exp, name);
  endtask

  task automatic pulse(input logic [7:0] irq);
    cycle(irq, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack();
    cycle(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle the DUT presents interrupt and read data for the queued expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_interrupt", {7'b0, interrupt}, {7'b0, e.intr});
      chk("sb_data_out", data_out, e.data);
    end
  end

  initial begin
    // Asynchronous reset with the clock stopped.
    model_reset();
    ren = 1'b1; address = A_VEC;
    #2 rst = 1'b1;
    #3;
    chk("reset_interrupt", {7'b0, interrupt}, 8'h00);
    chk("reset_data_out", data_out, 8'h00);
    rst = 1'b0; ren = 1'b0;
    #5 clk_en = 1'b1;
    rd(A_MASK, 8'h00, "reset_mask");
    rd(A_PEND, 8'h00, "reset_pend");
    rd(A_VEC,  8'h00, "reset_vec");

    // Single request on source 2.
    wr(A_MASK, 8'h04);
    pulse(8'h04);
    idle(1);
    rd(A_VEC, 8'h82, "single_vec_busy");
    ack();
    wr(A_PEND, 8'h04);
    idle(1);
    rd(A_VEC, 8'h02, "single_vec_idle");

    // Priority: sources 5 and 1 together.
    wr(A_MASK, 8'hFF);
    pulse(8'h22);
    idle(1);
    rd(A_PEND, 8'h22, "prio_pend");
    rd(A_VEC, 8'h81, "prio_vec1");
    ack();
    wr(A_PEND, 8'h02);
    idle(2);
    rd(A_VEC, 8'h85, "prio_vec5");
    ack();
    wr(A_PEND, 8'h20);
    idle(2);

    // Masked then enabled.
    wr(A_MASK, 8'h00);
    pulse(8'h01);
    idle(1);
    rd(A_PEND, 8'h01, "masked_pend");
    idle(20);
    wr(A_MASK, 8'h01);
    idle(1);
    rd(A_VEC, 8'h80, "enabled_vec");
    ack();
    wr(A_PEND, 8'h01);
    idle(2);

    // Withdraw before ack, then set-beats-clear.
    wr(A_MASK, 8'h08);
    pulse(8'h08);
    idle(1);
    rd(A_VEC, 8'h83, "withdraw_busy");
    wr(A_PEND, 8'h08);
    idle(1);
    rd(A_VEC, 8'h03, "withdraw_idle");
    cycle(8'h08, A_PEND, 8'h08, 1'b0, 1'b1, 1'b0);
    rd(A_PEND, 8'h08, "set_beats_clear");
    ack();
    wr(A_PEND, 8'h08);
    idle(2);

    // Reset in the middle of a raised request.
    wr(A_MASK, 8'h01);
    pulse(8'h01);
    idle(1);
    @(negedge clk);
    #3 rst = 1'b1;
    model_reset();
    #1 chk("midreset_interrupt", {7'b0, interrupt}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(A_MASK, 8'h00, "midreset_mask");
    rd(A_PEND, 8'h00, "midreset_pend");
    rd(A_VEC,  8'h00, "midreset_vec");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] a, d, irq;
      logic       r, w, k;
      irq = 8'($urandom & $urandom);
      case ($urandom_range(0, 4))
        0: a = A_MASK;
        1: a = A_PEND;
        2: a = A_VEC;
        3: a = 8'h00;
        default: a = 8'h04;
      endcase
      d = 8'($urandom);
      r = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 4) == 0);
      k = ($urandom_range(0, 3) == 0);
      cycle(irq, a, d, r, w, k);
    end
    idle(3);

    @(negedge clk);
    #3;
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
